// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator's sequential
// multiply/divide controller.
package calc_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_MUL_STEP,
    S_MUL_SHIFT,
    S_DIV_SHIFT,
    S_DIV_SUB,
    S_DIV_CHECK,
    S_FINISH,
    S_HOLD,
    S_ERR
  } state_e;

endpackage

// File: rtl/start_edge.sv
// Rising-edge detector for a level start request. It fires only after the
// input has been seen low, so a level held through reset never launches.
module start_edge (
  input  logic CLK,
  input  logic CLR,
  input  logic din,
  output logic rise
);

  logic armed;

  always_ff @(posedge CLK) begin
    if (CLR) armed <= 1'b0;
    else     armed <= ~din;
  end

  assign rise = din & armed;

endmodule

// File: rtl/muldiv_seq.sv
// Control sequencer for a shift-add multiplier and restoring divider.
// Emits one-cycle datapath strobes and busy/done/div-by-zero status.
module muldiv_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic CLK,
  input  logic CLR,
  input  logic START_MUL,
  input  logic START_DIV,
  input  logic B_ZERO,
  input  logic Q0,
  input  logic REM_NEG,
  output logic LD,
  output logic ADD_EN,
  output logic SHR,
  output logic SHL,
  output logic SUB_EN,
  output logic RESTORE,
  output logic SET_Q,
  output logic BUSY,
  output logic DONE,
  output logic DIV0
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e        st, st_nx;
  logic          op, op_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rise_mul, rise_div;

  start_edge u_edge_mul (.CLK(CLK), .CLR(CLR), .din(START_MUL), .rise(rise_mul));
  start_edge u_edge_div (.CLK(CLK), .CLR(CLR), .din(START_DIV), .rise(rise_div));

  always_comb begin
    st_nx  = st;
    op_nx  = op;
    cnt_nx = cnt;
    case (st)
      S_IDLE: begin
        // Multiply wins when both requests rise together.
        if (rise_mul) begin
          op_nx = OP_MUL;
          st_nx = S_LOAD;
        end else if (rise_div) begin
          op_nx = OP_DIV;
          st_nx = B_ZERO ? S_ERR : S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_nx = '0;
        st_nx  = (op == OP_MUL) ? S_MUL_STEP : S_DIV_SHIFT;
      end
      S_MUL_STEP:  st_nx = S_MUL_SHIFT;
      S_MUL_SHIFT: begin
        cnt_nx = cnt + ONE;
        st_nx  = (cnt == LAST) ? S_FINISH : S_MUL_STEP;
      end
      S_DIV_SHIFT: st_nx = S_DIV_SUB;
      S_DIV_SUB:   st_nx = S_DIV_CHECK;
      S_DIV_CHECK: begin
        cnt_nx = cnt + ONE;
        st_nx  = (cnt == LAST) ? S_FINISH : S_DIV_SHIFT;
      end
      S_FINISH: st_nx = S_HOLD;
      S_HOLD, S_ERR: begin
        if (!START_MUL && !START_DIV) st_nx = S_IDLE;
      end
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      st  <= S_IDLE;
      op  <= OP_MUL;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      op  <= op_nx;
      cnt <= cnt_nx;
    end
  end

  // ADD_EN / RESTORE / SET_Q follow the live datapath flags in their state.
  assign LD      = (st == S_LOAD);
  assign ADD_EN  = (st == S_MUL_STEP) & Q0;
  assign SHR     = (st == S_MUL_SHIFT);
  assign SHL     = (st == S_DIV_SHIFT);
  assign SUB_EN  = (st == S_DIV_SUB);
  assign RESTORE = (st == S_DIV_CHECK) & REM_NEG;
  assign SET_Q   = (st == S_DIV_CHECK) & ~REM_NEG;
  assign BUSY    = (st != S_IDLE) && (st != S_HOLD) && (st != S_ERR);
  assign DONE    = (st == S_FINISH);
  assign DIV0    = (st == S_ERR);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a small shift-add / restoring-divide
// datapath model closing the Q0 / REM_NEG loop.
module tb_muldiv_seq;

  localparam int W = 8;
  localparam logic [7:0] MCAND = 8'd13;
  localparam logic [7:0] MPLR  = 8'h0B;
  localparam logic [7:0] DVD   = 8'd100;
  localparam logic [7:0] DVS   = 8'd7;

  logic CLK = 1'b0;
  logic CLR, START_MUL, START_DIV, B_ZERO, Q0, REM_NEG;
  logic LD, ADD_EN, SHR, SHL, SUB_EN, RESTORE, SET_Q, BUSY, DONE, DIV0;
  logic [9:0] outs;

  int n_chk  = 0;
  int n_pass = 0;

  logic [16:0] P = '0;
  logic [8:0]  A = '0;
  logic [7:0]  Q = '0;

  muldiv_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .START_MUL(START_MUL), .START_DIV(START_DIV),
    .B_ZERO(B_ZERO), .Q0(Q0), .REM_NEG(REM_NEG),
    .LD(LD), .ADD_EN(ADD_EN), .SHR(SHR), .SHL(SHL), .SUB_EN(SUB_EN),
    .RESTORE(RESTORE), .SET_Q(SET_Q), .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0)
  );

  always #5 CLK = ~CLK;

  assign outs    = {LD, ADD_EN, SHR, SHL, SUB_EN, RESTORE, SET_Q, BUSY, DONE, DIV0};
  assign Q0      = P[0];
  assign REM_NEG = A[8];

  // Datapath model: P = {carry+acc, multiplier}, {A,Q} = remainder/quotient.
  always @(posedge CLK) begin
    if (LD) begin
      P <= {9'd0, MPLR};
      A <= '0;
      Q <= DVD;
    end else begin
      if (ADD_EN)  P[16:8] <= P[16:8] + {1'b0, MCAND};
      if (SHR)     P <= P >> 1;
      if (SHL)     {A, Q} <= {A[7:0], Q, 1'b0};
      if (SUB_EN)  A <= A - {1'b0, DVS};
      if (RESTORE) A <= A + {1'b0, DVS};
      if (SET_Q)   Q[0] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
  endtask

  // Bits: LD ADD_EN SHR SHL SUB_EN RESTORE SET_Q BUSY DONE DIV0
  function automatic logic [9:0] exp_mul(input int c);
    logic [9:0] e;
    e    = '0;
    e[9] = (c == 1);
    e[8] = (c == 2) || (c == 4) || (c == 8);   // multiplier 0x0B: bits 0,1,3
    e[7] = (c >= 3) && (c <= 17) && (c % 2 == 1);
    e[2] = (c >= 1) && (c <= 18);
    e[1] = (c == 18);
    return e;
  endfunction

  function automatic logic [9:0] exp_div(input int c);
    logic [9:0] e;
    logic [7:0] qseq;
    int k;
    e    = '0;
    qseq = 8'b0111_0000;                         // 100/7 quotient bits per step
    e[9] = (c == 1);
    if (c >= 2 && c <= 25) begin
      k = (c - 2) / 3;
      case ((c - 2) % 3)
        0:       e[6] = 1'b1;
        1:       e[5] = 1'b1;
        default: if (qseq[k]) e[3] = 1'b1; else e[4] = 1'b1;
      endcase
    end
    e[2] = (c >= 1) && (c <= 26);
    e[1] = (c == 26);
    return e;
  endfunction

  task automatic run_mul(input string tag);
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk(tag, c, 32'(outs), 32'(exp_mul(c)));
    end
    chk({tag, "_prod"}, 18, 32'(P[15:0]), 32'd143);
  endtask

  initial begin
    CLR = 1'b1; START_MUL = 1'b0; START_DIV = 1'b0; B_ZERO = 1'b0;
    tick(); tick();
    chk("reset", 0, 32'(outs), 32'd0);
    CLR = 1'b0;
    tick();
    chk("idle", 0, 32'(outs), 32'd0);

    // Multiply 13 x 11, then hold the request: no relaunch.
    START_MUL = 1'b1;
    run_mul("mul");
    for (int c = 19; c <= 21; c++) begin
      tick();
      chk("mul_hold", c, 32'(outs), 32'd0);
    end
    START_MUL = 1'b0;
    tick();
    chk("mul_idle", 22, 32'(outs), 32'd0);

    // Divide 100 / 7, request dropped mid-operation.
    START_DIV = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      chk("div", c, 32'(outs), 32'(exp_div(c)));
      if (c == 10) START_DIV = 1'b0;
    end
    chk("div_quot", 26, 32'(Q), 32'd14);
    chk("div_rem", 26, 32'(A), 32'd2);
    tick();
    chk("div_after", 27, 32'(outs), 32'd0);
    tick();

    // Divide by zero: DIV0 only, until the request drops.
    B_ZERO = 1'b1;
    START_DIV = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("div0", c, 32'(outs), 32'd1);
    end
    START_DIV = 1'b0;
    tick();
    chk("div0_exit", 6, 32'(outs), 32'd0);
    B_ZERO = 1'b0;
    tick();

    // Reset mid-multiply; held request must not relaunch.
    START_MUL = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("clr_pre", c, 32'(outs), 32'(exp_mul(c)));
    end
    CLR = 1'b1;
    tick();
    chk("clr_zero", 6, 32'(outs), 32'd0);
    CLR = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      tick();
      chk("clr_held", c, 32'(outs), 32'd0);
    end
    START_MUL = 1'b0;
    tick();
    chk("clr_low", 11, 32'(outs), 32'd0);
    START_MUL = 1'b1;
    run_mul("mul_relaunch");
    START_MUL = 1'b0;
    tick(); tick();

    // Coincident requests: multiply wins, neither relaunches while held.
    START_MUL = 1'b1;
    START_DIV = 1'b1;
    run_mul("both");
    for (int c = 19; c <= 21; c++) begin
      tick();
      chk("both_hold", c, 32'(outs), 32'd0);
    end
    START_MUL = 1'b0;
    START_DIV = 1'b0;
    tick();
    chk("both_idle", 22, 32'(outs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width and iteration count of the multiply/divide datapath.
REQ-002 SHALL have port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: CLR  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: START_MUL  input  1  level request for multiply from the calculator controller.
REQ-005 SHALL have port: START_DIV  input  1  level request for divide from the calculator controller.
REQ-006 SHALL have port: B_ZERO  input  1  datapath flag: divisor register equals zero.
REQ-007 SHALL have port: Q0  input  1  datapath flag: multiplier register LSB.
REQ-008 SHALL have port: REM_NEG  input  1  datapath flag: trial remainder is negative.
REQ-009 SHALL have ports: LD, ADD_EN, SHR, SHL, SUB_EN, RESTORE, SET_Q  output  1 each  one-cycle datapath control strobes.
REQ-010 SHALL have ports: BUSY, DONE, DIV0  output  1 each  status: operation in progress, one-cycle completion pulse, divide-by-zero error.

Function
REQ-011 SHALL launch only on a rising edge (low in the previous cycle, high now) of START_MUL or START_DIV while in IDLE; held levels SHALL NOT relaunch.
REQ-012 SHALL give START_MUL priority when both rising edges coincide.
REQ-013 SHALL implement states IDLE, LOAD, MUL_STEP, MUL_SHIFT, DIV_SHIFT, DIV_SUB, DIV_CHECK, FINISH, HOLD, ERR.
REQ-014 IDLE: launch mul -> LOAD; launch div with B_ZERO=0 -> LOAD; launch div with B_ZERO=1 -> ERR.
REQ-015 LOAD: LD=1, step counter cleared to 0; -> MUL_STEP (mul) or DIV_SHIFT (div).
REQ-016 MUL_STEP: ADD_EN=Q0; -> MUL_SHIFT.
REQ-017 MUL_SHIFT: SHR=1; counter increments; counter==WIDTH-1 before increment -> FINISH, else -> MUL_STEP.
REQ-018 DIV_SHIFT: SHL=1 -> DIV_SUB: SUB_EN=1 -> DIV_CHECK.
REQ-019 DIV_CHECK: REM_NEG=1 gives RESTORE=1, SET_Q=0; REM_NEG=0 gives SET_Q=1; counter increments; last step -> FINISH, else -> DIV_SHIFT.
REQ-020 FINISH: DONE=1 for exactly one cycle; -> HOLD.
REQ-021 HOLD and ERR: remain until START_MUL=0 and START_DIV=0, then -> IDLE.
REQ-022 ERR: DIV0=1 for every cycle in ERR; no datapath strobe asserted.
REQ-023 BUSY SHALL be 1 in LOAD through FINISH inclusive, 0 elsewhere.
REQ-024 Latency, launch edge sampled at cycle 0: LOAD at cycle 1; mul DONE at cycle 2*WIDTH+2; div DONE at cycle 3*WIDTH+2.
REQ-025 START deassertion mid-operation SHALL be ignored; the operation completes.
REQ-026 Counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within one operation.
REQ-027 All outputs SHALL be registered-state decodes (Moore) except ADD_EN, RESTORE and SET_Q, which depend on the current Q0 and REM_NEG.

Reset
REQ-028 CLR=1 at a rising edge SHALL force IDLE, counter 0 and start-history 0, overriding every other condition, including mid-operation.
REQ-029 During and after reset all outputs SHALL be 0; a fresh rising start edge SHALL be required after CLR releases.

Structure
REQ-030 A shared package calc_pkg SHALL hold the state enum, default WIDTH constant and mul/div opcode constants.
REQ-031 One sub-module start_edge (registered rising-edge detector, same CLK/CLR) SHALL be instantiated once per start input.

Verification (WIDTH=8, bench models datapath)
REQ-032 Mul 13x11 (B=0x0B): ADD_EN high in steps 0,1,3 only, 8 SHR pulses, DONE at cycle 18, BUSY cycles 1-18.
REQ-033 Div 100/7: SET_Q sequence 0,0,0,0,1,1,1,0 (quotient 14), RESTORE on the complementary steps, DONE at cycle 26.
REQ-034 Div with B_ZERO=1: DIV0=1 from cycle 1 until START_DIV drops, BUSY and all strobes 0, DONE never.
REQ-035 CLR pulsed at cycle 5 of a mul: all outputs 0 next cycle; a held START_MUL does not relaunch; a new edge gives DONE 18 cycles later.
REQ-036 START_MUL and START_DIV rising together: multiply executes (DONE at cycle 18, no SUB_EN), and neither relaunches while held.
